// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a master and apb_slave_regfile.
// pstrb exists only when APB_PSTRB_EN is defined.
interface apb_slave_regfile_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
`ifdef APB_PSTRB_EN
  logic [3:0]        pstrb;
`endif
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
`ifdef APB_PSTRB_EN
    output pstrb,
`endif
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
`ifdef APB_PSTRB_EN
    input  pstrb,
`endif
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB slave register file: NUM_REGS x 32-bit registers, fixed wait states, pslverr on bad address.
// Define APB_PSTRB_EN to add byte write strobes (pstrb); default build writes whole words.
module apb_slave_regfile #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                pclk,
  input  logic                presetn,
  apb_slave_regfile_if.slave  apb,
  output logic [31:0]         ctrl_q
);

  localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be;
  logic [31:0]       regs_q [NUM_REGS];

  logic [31:0]       word_idx;
  logic [IdxW-1:0]   sel;
  logic              err;
  logic              ready;
  logic              we;

`ifdef APB_PSTRB_EN
  logic [3:0] strb_q, strb_d;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      strb_q <= '0;
    end else begin
      strb_q <= strb_d;
    end
  end

  always_comb begin
    strb_d = strb_q;
    if (state_q == StIdle && apb.psel && !apb.penable) begin
      strb_d = apb.pstrb;
    end
  end

  assign be = strb_q;
`else
  assign be = 4'hF;
`endif

  assign word_idx = 32'(addr_q[ADDR_W-1:2]);
  assign sel      = word_idx[IdxW-1:0];
  assign err      = (word_idx >= NUM_REGS) || (addr_q[1:0] != 2'b00);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // An enable with no preceding setup phase is not a transfer start.
        if (apb.psel && !apb.penable) begin
          state_d = StAccess;
          cnt_d   = 4'(WAIT_CYCLES);
          wr_d    = apb.pwrite;
          addr_d  = apb.paddr;
          wdata_d = apb.pwdata;
        end
      end
      StAccess: begin
        if (!apb.psel) begin
          state_d = StIdle;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (apb.penable) begin
          state_d = StIdle;
          we      = wr_q && !err;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ready       = (state_q == StIdle) || (cnt_q == 4'd0);
  assign apb.pready  = ready;
  assign apb.pslverr = (state_q == StAccess) && (cnt_q == 4'd0) && err;
  assign apb.prdata  = ((state_q == StAccess) && (cnt_q == 4'd0) && !err && !wr_q) ?
                       regs_q[sel] : 32'h0;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) begin
          regs_q[sel][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign ctrl_q = regs_q[0];

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench: a WAIT_CYCLES=1 and a WAIT_CYCLES=3 instance share one stimulus bus.
// Table-driven vectors plus hand sequences; expected responses flow through a scoreboard queue.
module tb_apb_slave_regfile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        dsel;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  apb_slave_regfile_if #(.ADDR_W(8)) if1 ();
  apb_slave_regfile_if #(.ADDR_W(8)) if3 ();

  assign if1.psel    = psel & ~dsel;
  assign if1.penable = penable;
  assign if1.pwrite  = pwrite;
  assign if1.paddr   = paddr;
  assign if1.pwdata  = pwdata;
  assign if3.psel    = psel & dsel;
  assign if3.penable = penable;
  assign if3.pwrite  = pwrite;
  assign if3.paddr   = paddr;
  assign if3.pwdata  = pwdata;
`ifdef APB_PSTRB_EN
  assign if1.pstrb   = pstrb;
  assign if3.pstrb   = pstrb;
`endif

  logic [31:0] ctrl1, ctrl3;

  apb_slave_regfile #(.ADDR_W(8), .NUM_REGS(8), .WAIT_CYCLES(1)) u_dut1 (
    .pclk    (clk),
    .presetn (rst_n),
    .apb     (if1),
    .ctrl_q  (ctrl1)
  );

  apb_slave_regfile #(.ADDR_W(8), .NUM_REGS(8), .WAIT_CYCLES(3)) u_dut3 (
    .pclk    (clk),
    .presetn (rst_n),
    .apb     (if3),
    .ctrl_q  (ctrl3)
  );

  logic        pready_m, pslverr_m;
  logic [31:0] prdata_m, ctrl_m;
  assign pready_m  = dsel ? if3.pready  : if1.pready;
  assign pslverr_m = dsel ? if3.pslverr : if1.pslverr;
  assign prdata_m  = dsel ? if3.prdata  : if1.prdata;
  assign ctrl_m    = dsel ? ctrl3       : ctrl1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    logic        rd;
  } exp_t;

  exp_t sb[$];

  // Entered and left on a falling edge; leaves the bus idle so a setup may follow at once.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic corrupt,
                      output logic [31:0] rdata, output logic err, output int waits,
                      output logic [31:0] ctrl_at_done);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    if (corrupt) begin
      pwdata = 32'h0;
      paddr  = addr + 8'd4;
      pstrb  = 4'h0;
    end
    waits = 0;
    while (!pready_m && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    rdata        = prdata_m;
    err          = pslverr_m;
    ctrl_at_done = ctrl_m;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic run(input string name, input logic wr, input logic [7:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb, input logic corrupt,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_waits,
                     output logic [31:0] ctrl_done);
    exp_t        e;
    logic [31:0] rdata;
    logic        err;
    int          waits;
    e.rdata = exp_rdata; e.err = exp_err; e.waits = exp_waits; e.rd = !wr;
    sb.push_back(e);
    xfer(wr, addr, wdata, strb, corrupt, rdata, err, waits, ctrl_done);
    e = sb.pop_front();
    check({name, " pslverr"}, 32'(err), 32'(e.err));
    check({name, " wait cycles"}, 32'(waits), 32'(e.waits));
    if (e.rd) check({name, " prdata"}, rdata, e.rdata);
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vt [18];

  initial begin
    logic [31:0] cd;
    logic [31:0] exp_ctrl;

    vt[0]  = '{1'b0, 8'h00, 32'h0, 32'h0, 1'b0};
    vt[1]  = '{1'b0, 8'h04, 32'h0, 32'h0, 1'b0};
    vt[2]  = '{1'b0, 8'h08, 32'h0, 32'h0, 1'b0};
    vt[3]  = '{1'b0, 8'h0C, 32'h0, 32'h0, 1'b0};
    vt[4]  = '{1'b0, 8'h10, 32'h0, 32'h0, 1'b0};
    vt[5]  = '{1'b0, 8'h14, 32'h0, 32'h0, 1'b0};
    vt[6]  = '{1'b0, 8'h18, 32'h0, 32'h0, 1'b0};
    vt[7]  = '{1'b0, 8'h1C, 32'h0, 32'h0, 1'b0};
    vt[8]  = '{1'b1, 8'h00, 32'hDEADBEEF, 32'h0, 1'b0};
    vt[9]  = '{1'b1, 8'h1C, 32'hCAFEF00D, 32'h0, 1'b0};
    vt[10] = '{1'b0, 8'h00, 32'h0, 32'hDEADBEEF, 1'b0};
    vt[11] = '{1'b1, 8'h20, 32'h12345678, 32'h0, 1'b1};
    vt[12] = '{1'b0, 8'h20, 32'h0, 32'h0, 1'b1};
    vt[13] = '{1'b1, 8'h05, 32'h87654321, 32'h0, 1'b1};
    vt[14] = '{1'b0, 8'h04, 32'h0, 32'h0, 1'b0};
    vt[15] = '{1'b0, 8'h00, 32'h0, 32'hDEADBEEF, 1'b0};
    vt[16] = '{1'b0, 8'h1C, 32'h0, 32'hCAFEF00D, 1'b0};
    vt[17] = '{1'b0, 8'h03, 32'h0, 32'h0, 1'b1};

    dsel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = 4'hF;
    exp_ctrl = 32'h0;

    repeat (2) @(negedge clk);
    check("reset pready", 32'(if1.pready), 32'd1);
    check("reset pslverr", 32'(if1.pslverr), 32'd0);
    check("reset prdata", if1.prdata, 32'h0);
    check("reset ctrl_q", ctrl1, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      run($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].wdata, 4'hF, 1'b0,
          vt[i].rdata, vt[i].err, 1, cd);
      if (vt[i].wr && !vt[i].err && vt[i].addr == 8'h00) begin
        check($sformatf("vec%0d ctrl_q at completion", i), cd, exp_ctrl);
        exp_ctrl = vt[i].wdata;
        check($sformatf("vec%0d ctrl_q after write", i), ctrl1, exp_ctrl);
      end
    end
    check("ctrl_q after error writes", ctrl1, 32'hDEADBEEF);

    // Enable without setup must not start or complete a transfer.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h0BAD0BAD;
    @(negedge clk);
    check("orphan enable pready", 32'(if1.pready), 32'd1);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    run("orphan readback", 1'b0, 8'h10, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1, cd);

    // Three wait states; data and address changed during ACCESS must be ignored.
    dsel = 1'b1;
    run("w3 write", 1'b1, 8'h04, 32'hA5A5A5A5, 4'hF, 1'b1, 32'h0, 1'b0, 3, cd);
    run("w3 read reg1", 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 32'hA5A5A5A5, 1'b0, 3, cd);
    run("w3 read reg2", 1'b0, 8'h08, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 3, cd);
    dsel = 1'b0;

    // psel dropped mid-ACCESS aborts without writing.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h00000077;
    @(negedge clk);
    psel = 1'b0;
    @(negedge clk);
    check("abort pslverr", 32'(if1.pslverr), 32'd0);
    run("abort readback", 1'b0, 8'h0C, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1, cd);

`ifdef APB_PSTRB_EN
    run("strb full", 1'b1, 8'h0C, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 1'b0, 1, cd);
    run("strb 0101", 1'b1, 8'h0C, 32'h11223344, 4'h5, 1'b0, 32'h0, 1'b0, 1, cd);
    run("strb none", 1'b1, 8'h0C, 32'h00000000, 4'h0, 1'b0, 32'h0, 1'b0, 1, cd);
    run("strb read", 1'b0, 8'h0C, 32'h0, 4'h0, 1'b0, 32'hFF22FF44, 1'b0, 1, cd);
`endif

    // Reset during ACCESS of a write to reg2.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h55AA55AA;
    @(negedge clk);
    penable = 1'b1;
    rst_n = 1'b0;
    #1;
    check("reset mid pready", 32'(if1.pready), 32'd1);
    check("reset mid pslverr", 32'(if1.pslverr), 32'd0);
    check("reset mid ctrl_q", ctrl1, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("reset read reg2", 1'b0, 8'h08, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1, cd);
    run("reset read reg0", 1'b0, 8'h00, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1, cd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
